alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Multi-cycle accumulator control unit; the initiator that drives the 4-bit ALU.
//  Fetches 8-bit instructions over a req/ack port and decodes them into
//  alu_operation_t plus two operands, then writes back the ALU result and zero flag.
//  Also executes jumps, conditional branch on zero and an output handshake.
//  Sits between instruction memory and the ALU as the top-level datapath controller.
// PARAMETERS
//  ADDR_W    4  PC / imem address width; legal range 4..8; 4-bit targets zero-extended
//  RESET_PC  0  PC value loaded on reset
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset          in   1       synchronous, active-high
//  imem_req       out  1       fetch request
//  imem_addr      out  ADDR_W  fetch address (= pc)
//  imem_ack       in   1       fetch complete; imem_data valid this cycle
//  imem_data      in   8       instruction {opcode[7:4], imm[3:0]}
//  alu_op1        out  4       ALU op1 = imm
//  alu_op2        out  4       ALU op2 = acc
//  alu_operation  out  alu_operation_t  decoded ALU operation
//  alu_result     in   4       ALU result
//  alu_zero       in   1       ALU zero flag
//  out_valid      out  1       out_data valid
//  out_ready      in   1       consumer accepts out_data
//  out_data       out  4       accumulator value for OUT
//  halted         out  1       HALT executed
// BEHAVIOUR
//  Reset values: pc=RESET_PC, acc=0, zf=0, instr=0, state=FETCH.
//  Output reset values: imem_req=0, out_valid=0, halted=0.
//  Reset also wins over every other event, including mid-fetch, OUT wait and HALTED.
//  Reset abandons any outstanding fetch; imem must tolerate a dropped request.
//  States: FETCH, EXEC, OUT_WAIT, HALTED.
//  FETCH:
//   - imem_req=1, imem_addr=pc, held stable until imem_ack.
//   - On ack: instr<=imem_data, next state EXEC. Ack in the first request cycle is legal.
//  EXEC (one cycle); ALU path is combinational, result captured at end of EXEC.
//   - 0 NOP: no data update.
//   - 1..7 ADD SUB AND OR XOR LT LSL: alu_operation set to the matching ALU_* value.
//     acc<=alu_result, zf<=alu_zero. Result is op2 OP op1, i.e. acc OP imm.
//     SUB is acc-imm; LT is acc<imm; LSL is acc<<imm. All mod 16, no carry kept.
//   - 8 LDI: acc<=imm; zf unchanged.
//   - 9 JMP: pc<=imm.
//   - A JZ: pc<=imm if zf=1, else pc+1.
//   - B OUT: next state OUT_WAIT; pc not yet advanced.
//   - C..E reserved: executed as NOP.
//   - F HALT: next state HALTED; pc not advanced.
//   - All other opcodes: pc<=pc+1 (mod 2^ADDR_W, wraps), then FETCH.
//  alu_operation outside EXEC of an ALU opcode: ALU_ADD; result is ignored.
//  OUT_WAIT:
//   - out_valid=1, out_data=acc, stable until out_ready.
//   - The cycle out_valid&&out_ready is the transfer: pc<=pc+1, then FETCH.
//  HALTED: halted=1, imem_req=0, no state change; only reset exits.
//  Instruction latency = fetch cycles + 1 (minimum 2); OUT adds >=1 cycle.
// TESTING
//  LDI 5; ADD 3; OUT, ready=1 -> out_data=8 for one cycle, zf=0, next fetch addr 3.
//  LDI 1; LSL 3; ADD 8 -> acc 8, then acc 0 (wrap) with zf=1.
//  LDI 3; SUB 3; JZ 9 -> zf=1, imem_addr=9. Repeat with SUB 2 -> imem_addr=3.
//  imem_ack held low 3 cycles -> imem_req=1 and imem_addr constant all 4 cycles; acc/pc frozen.
//  OUT with out_ready low 4 cycles -> out_valid=1, out_data stable; pc advances only on ready.
//  JMP 15; NOP at 15 -> next fetch addr 0. HALT -> halted=1, imem_req=0.
//  Reset in HALTED -> fetch addr 0. Reset during OUT_WAIT -> out_valid=0 next cycle.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// ALU operation type and the sequencer's imem / ALU / output bundle.
// master = sequencer side, slave = memory, ALU and output consumer side.
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_LT  = 3'd5,
    ALU_LSL = 3'd6
  } alu_operation_t;
endpackage

interface alu_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic                  imem_req;
  logic [ADDR_W-1:0]     imem_addr;
  logic                  imem_ack;
  logic [7:0]            imem_data;
  logic [3:0]            alu_op1;
  logic [3:0]            alu_op2;
  alu_pkg::alu_operation_t alu_operation;
  logic [3:0]            alu_result;
  logic                  alu_zero;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            out_data;
  logic                  halted;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_data,
    output alu_op1, alu_op2, alu_operation,
    input  alu_result, alu_zero,
    output out_valid, out_data, halted,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_data,
    input  alu_op1, alu_op2, alu_operation,
    output alu_result, alu_zero,
    input  out_valid, out_data, halted,
    output out_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Accumulator controller: fetch over req/ack, one EXEC cycle driving the ALU, OUT via valid/ready.
// Latency per instruction = fetch cycles + 1; OUT stalls in OUT_WAIT until out_ready.
module alu_sequencer #(
  parameter int                ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           reset,
  alu_sequencer_if.master bus
);
  import alu_pkg::*;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_OUT_WAIT, S_HALTED} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        acc_q, acc_d;
  logic              zf_q, zf_d;
  logic [7:0]        instr_q, instr_d;
  logic              req_q, valid_q, halted_q;
  alu_operation_t    alu_sel;

  logic [3:0]        opcode, imm;
  logic [ADDR_W-1:0] pc_inc, imm_ext;

  assign opcode  = instr_q[7:4];
  assign imm     = instr_q[3:0];
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign imm_ext = ADDR_W'(imm);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    zf_d    = zf_q;
    instr_d = instr_q;
    alu_sel = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        if (req_q && bus.imem_ack) begin
          instr_d = bus.imem_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (opcode)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
            // Opcodes 1..7 map onto ALU_ADD..ALU_LSL in order.
            alu_sel = alu_operation_t'(opcode[2:0] - 3'd1);
            acc_d   = bus.alu_result;
            zf_d    = bus.alu_zero;
          end
          4'h8: acc_d = imm;
          4'h9: pc_d = imm_ext;
          4'hA: if (zf_q) pc_d = imm_ext;
          4'hB: begin
            state_d = S_OUT_WAIT;
            pc_d    = pc_q;
          end
          4'hF: begin
            state_d = S_HALTED;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      S_OUT_WAIT: begin
        if (valid_q && bus.out_ready) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALTED: ;
      default: ;
    endcase
  end

  // Handshake outputs are registered from the next state, so they read 0 straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      acc_q    <= 4'd0;
      zf_q     <= 1'b0;
      instr_q  <= 8'd0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      zf_q     <= zf_d;
      instr_q  <= instr_d;
      req_q    <= (state_d == S_FETCH);
      valid_q  <= (state_d == S_OUT_WAIT);
      halted_q <= (state_d == S_HALTED);
    end
  end

  assign bus.imem_req      = req_q;
  assign bus.imem_addr     = pc_q;
  assign bus.alu_op1       = imm;
  assign bus.alu_op2       = acc_q;
  assign bus.alu_operation = alu_sel;
  assign bus.out_valid     = valid_q;
  assign bus.out_data      = acc_q;
  assign bus.halted        = halted_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ISA-level reference model, behavioural ALU and imem, random programs.
`timescale 1ns/1ps
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  alu_sequencer_if #(.ADDR_W(AW)) bus ();

  alu_sequencer #(.ADDR_W(AW), .RESET_PC(4'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  int ready_delay = 0;
  logic [7:0] mem [16];

  // model state
  int  m_pc, m_acc, m_zf;
  bit  m_halt, m_outp, prev_ack, prev_reset;
  int  ex_op, ex_imm, ex_acc;
  int  fetch_log[$];
  int  out_log[$];
  int  req_run, last_req_run, valid_run, last_valid_run;
  alu_operation_t exp_ops [16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] alu_f(alu_operation_t op, logic [3:0] a, logic [3:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_LT:  return (a < b) ? 4'd1 : 4'd0;
      ALU_LSL: return a << b;
      default: return 4'd0;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_operation, bus.alu_op2, bus.alu_op1);
  assign bus.alu_zero   = (bus.alu_result == 4'd0);

  function automatic int model_alu(int opc, int acc, int imm);
    case (opc)
      1: return (acc + imm) % 16;
      2: return (acc - imm + 16) % 16;
      3: return acc & imm;
      4: return acc | imm;
      5: return acc ^ imm;
      6: return (acc < imm) ? 1 : 0;
      7: return (acc << imm) & 15;
      default: return 0;
    endcase
  endfunction

  function automatic int flog(int i);
    if (i < fetch_log.size()) return fetch_log[i];
    return -1;
  endfunction

  function automatic int olog(int i);
    if (i < out_log.size()) return out_log[i];
    return -1;
  endfunction

  initial begin : imem_driver
    int wait_n, tgt;
    bit fresh;
    bus.imem_ack = 1'b0;
    bus.imem_data = 8'h00;
    fresh = 1'b1; wait_n = 0; tgt = 0;
    forever begin
      @(posedge clk); #2;
      bus.imem_ack = 1'b0;
      bus.imem_data = 8'h00;
      if (bus.imem_req && !reset) begin
        if (fresh) begin
          tgt = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 2));
          wait_n = 0;
          fresh = 1'b0;
        end
        if (wait_n >= tgt) begin
          bus.imem_ack = 1'b1;
          bus.imem_data = mem[bus.imem_addr];
          fresh = 1'b1;
        end else wait_n++;
      end else fresh = 1'b1;
    end
  end

  initial begin : out_driver
    int wait_n, tgt;
    bit fresh;
    bus.out_ready = 1'b0;
    fresh = 1'b1; wait_n = 0; tgt = 0;
    forever begin
      @(posedge clk); #2;
      if (bus.out_valid && !reset) begin
        if (fresh) begin
          tgt = (ready_delay >= 0) ? ready_delay : int'($urandom_range(0, 3));
          wait_n = 0;
          fresh = 1'b0;
        end
        if (wait_n >= tgt) begin
          bus.out_ready = 1'b1;
          fresh = 1'b1;
        end else begin
          bus.out_ready = 1'b0;
          wait_n++;
        end
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
        fresh = 1'b1;
      end
    end
  end

  // Reference model: one instruction per observed fetch, timing from the instruction latency rules.
  initial begin : compare
    int op, imm, npc;
    for (int i = 0; i < 16; i++) exp_ops[i] = ALU_ADD;
    exp_ops[2] = ALU_SUB; exp_ops[3] = ALU_AND; exp_ops[4] = ALU_OR;
    exp_ops[5] = ALU_XOR; exp_ops[6] = ALU_LT;  exp_ops[7] = ALU_LSL;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_pc = 0; m_acc = 0; m_zf = 0;
        m_halt = 1'b0; m_outp = 1'b0; prev_ack = 1'b0; prev_reset = 1'b1;
        fetch_log.delete(); out_log.delete();
        req_run = 0; valid_run = 0;
      end else begin
        chk("imem_req", int'(bus.imem_req), int'(!m_halt && !m_outp && !prev_ack && !prev_reset));
        chk("out_valid", int'(bus.out_valid), int'(m_outp && !prev_ack));
        chk("halted", int'(bus.halted), int'(m_halt && !prev_ack));
        if (bus.imem_req) chk("imem_addr", int'(bus.imem_addr), m_pc);
        if (bus.out_valid) chk("out_data", int'(bus.out_data), m_acc);
        if (prev_ack && ex_op >= 1 && ex_op <= 7) begin
          chk("alu_operation", int'(bus.alu_operation), int'(exp_ops[ex_op]));
          chk("alu_op1", int'(bus.alu_op1), ex_imm);
          chk("alu_op2", int'(bus.alu_op2), ex_acc);
        end else begin
          chk("alu_operation_idle", int'(bus.alu_operation), int'(ALU_ADD));
        end
        prev_reset = 1'b0;

        if (bus.out_valid) valid_run++; else valid_run = 0;
        if (bus.out_valid && bus.out_ready) begin
          last_valid_run = valid_run;
          valid_run = 0;
          out_log.push_back(int'(bus.out_data));
          m_pc = (m_pc + 1) % 16;
          m_outp = 1'b0;
        end

        prev_ack = 1'b0;
        if (bus.imem_req) req_run++; else req_run = 0;
        if (bus.imem_req && bus.imem_ack) begin
          last_req_run = req_run;
          req_run = 0;
          fetch_log.push_back(int'(bus.imem_addr));
          op = int'(mem[m_pc][7:4]);
          imm = int'(mem[m_pc][3:0]);
          ex_op = op; ex_imm = imm; ex_acc = m_acc;
          npc = (m_pc + 1) % 16;
          if (op >= 1 && op <= 7) begin
            m_acc = model_alu(op, m_acc, imm);
            m_zf = (m_acc == 0) ? 1 : 0;
          end else if (op == 8) m_acc = imm;
          else if (op == 9) npc = imm;
          else if (op == 10) begin
            if (m_zf != 0) npc = imm;
          end else if (op == 11) begin
            m_outp = 1'b1;
            npc = m_pc;
          end else if (op == 15) begin
            m_halt = 1'b1;
            npc = m_pc;
          end
          m_pc = npc;
          prev_ack = 1'b1;
        end
      end
    end
  end

  task automatic begin_test();
    @(posedge clk); #1 reset = 1'b1;
    for (int a = 0; a < 16; a++) mem[a] = 8'h00;
  endtask

  task automatic end_reset();
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_fetches(input int n);
    int budget;
    budget = 400;
    while (fetch_log.size() < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    if (fetch_log.size() < n) chk("fetch_timeout", fetch_log.size(), n);
  endtask

  function automatic logic [7:0] rand_instr();
    logic [3:0] op, imm;
    op = 4'($urandom_range(0, 15));
    imm = 4'($urandom_range(0, 15));
    if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'hB;
    return {op, imm};
  endfunction

  initial begin : main
    int budget;
    for (int a = 0; a < 16; a++) mem[a] = 8'h00;
    repeat (2) @(posedge clk);

    // LDI 5; ADD 3; OUT
    begin_test(); mem[0] = 8'h85; mem[1] = 8'h13; mem[2] = 8'hB0; end_reset();
    wait_fetches(4);
    chk("t1_out_count", out_log.size(), 1);
    chk("t1_out_data", olog(0), 8);
    chk("t1_next_addr", flog(3), 3);
    chk("t1_model_acc", m_acc, 8);
    chk("t1_model_zf", m_zf, 0);

    // LDI 1; LSL 3; OUT; ADD 8; OUT; JZ 9
    begin_test();
    mem[0] = 8'h81; mem[1] = 8'h73; mem[2] = 8'hB0; mem[3] = 8'h18; mem[4] = 8'hB0; mem[5] = 8'hA9;
    end_reset();
    wait_fetches(7);
    chk("t2_out0", olog(0), 8);
    chk("t2_out1_wrap", olog(1), 0);
    chk("t2_jz_taken", flog(6), 9);
    chk("t2_model_zf", m_zf, 1);

    // LDI 3; SUB 3; JZ 9  then  SUB 2
    begin_test(); mem[0] = 8'h83; mem[1] = 8'h23; mem[2] = 8'hA9; end_reset();
    wait_fetches(4);
    chk("t3_jz_taken", flog(3), 9);
    begin_test(); mem[0] = 8'h83; mem[1] = 8'h22; mem[2] = 8'hA9; end_reset();
    wait_fetches(4);
    chk("t3_jz_not_taken", flog(3), 3);

    // ack held low for 3 cycles
    ack_delay = 3;
    begin_test(); mem[0] = 8'h85; mem[1] = 8'h13; end_reset();
    wait_fetches(2);
    chk("t4_req_cycles", last_req_run, 4);
    ack_delay = 0;

    // out_ready low for 4 cycles
    ready_delay = 4;
    begin_test(); mem[0] = 8'h87; mem[1] = 8'hB0; end_reset();
    wait_fetches(3);
    chk("t5_out_data", olog(0), 7);
    chk("t5_valid_cycles", last_valid_run, 5);
    chk("t5_pc_after_out", flog(2), 2);
    ready_delay = 0;

    // JMP 15; NOP at 15 wraps to 0
    begin_test(); mem[0] = 8'h9F; end_reset();
    wait_fetches(3);
    chk("t6_jmp_target", flog(1), 15);
    chk("t6_wrap", flog(2), 0);

    // JMP 5; HALT at 5; then reset out of HALTED
    begin_test(); mem[0] = 8'h95; mem[5] = 8'hF0; end_reset();
    wait_fetches(2);
    repeat (4) @(posedge clk);
    #1;
    chk("t7_halt_addr", flog(1), 5);
    chk("t7_halted", int'(bus.halted), 1);
    chk("t7_req_low", int'(bus.imem_req), 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    wait_fetches(1);
    chk("t7_restart_addr", flog(0), 0);

    // reset while stalled in OUT_WAIT
    ready_delay = 100;
    begin_test(); mem[0] = 8'h85; mem[1] = 8'hB0; end_reset();
    budget = 60;
    while (!bus.out_valid && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("t8_out_wait_reached", int'(bus.out_valid), 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("t8_valid_after_reset", int'(bus.out_valid), 0);
    reset = 1'b0;
    ready_delay = 0;

    // random programs with random ack and ready latencies
    ack_delay = -1;
    ready_delay = -1;
    for (int ep = 0; ep < 40; ep++) begin
      begin_test();
      for (int a = 0; a < 16; a++) mem[a] = rand_instr();
      end_reset();
      repeat ($urandom_range(40, 250)) @(posedge clk);
    end

    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
